// File: rtl/multi_channel_synchronous_fifo.sv
// Single-clock FIFO holding CHANNEL_COUNT independent queues in one statically
// partitioned memory, with per-channel pointers, counts and registered flags.
module multi_channel_synchronous_fifo #(
  parameter int DATA_WIDTH              = 16,
  parameter int DATA_DEPTH              = 512,
  parameter int CHANNEL_COUNT           = 4,
  parameter int FIRST_WORD_FALL_THROUGH = 0,
  parameter int ALMOST_FULL_THRESHOLD   = DATA_DEPTH - 4,
  parameter int ALMOST_EMPTY_THRESHOLD  = 4,
  localparam int CW = $clog2(CHANNEL_COUNT),
  localparam int AW = $clog2(DATA_DEPTH),
  localparam int NW = AW + 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        write_enable,
  input  logic [CW-1:0]               write_channel,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        read_enable,
  input  logic [CW-1:0]               read_channel,
  output logic [DATA_WIDTH-1:0]       read_data,
  output logic                        read_data_valid,
  output logic [CW-1:0]               read_data_channel,
  output logic [CHANNEL_COUNT-1:0]    full,
  output logic [CHANNEL_COUNT-1:0]    empty,
  output logic [CHANNEL_COUNT-1:0]    almost_full,
  output logic [CHANNEL_COUNT-1:0]    almost_empty,
  output logic [CHANNEL_COUNT*NW-1:0] count,
  output logic                        write_overflow,
  output logic                        read_underflow
);

  localparam int MEM_WORDS = CHANNEL_COUNT * DATA_DEPTH;

  logic [DATA_WIDTH-1:0]       mem [0:MEM_WORDS-1];
  logic [CHANNEL_COUNT-1:0]    wr_hit;
  logic [CHANNEL_COUNT-1:0]    rd_hit;
  logic [CHANNEL_COUNT*AW-1:0] wr_ptr_flat;
  logic [CHANNEL_COUNT*AW-1:0] rd_ptr_flat;
  logic [AW-1:0]               wr_ptr_sel;
  logic [AW-1:0]               rd_ptr_sel;
  logic [CW+AW-1:0]            wr_addr;
  logic [CW+AW-1:0]            rd_addr;
  logic                        wr_accept;
  logic                        rd_accept;
  logic                        write_overflow_reg;
  logic                        read_underflow_reg;

  // Acceptance is decoded per channel so an out-of-range channel never matches.
  for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_chan
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [NW-1:0] count_reg;
    logic [NW-1:0] count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          almost_full_reg;
    logic          almost_empty_reg;

    assign wr_hit[gi] = write_enable && (write_channel == CW'(gi)) && !full_reg;
    assign rd_hit[gi] = read_enable && (read_channel == CW'(gi)) && !empty_reg;

    always_comb begin
      count_next = count_reg;
      case ({wr_hit[gi], rd_hit[gi]})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_reg       <= '0;
        rd_ptr_reg       <= '0;
        count_reg        <= '0;
        full_reg         <= 1'b0;
        empty_reg        <= 1'b1;
        almost_full_reg  <= 1'b0;
        almost_empty_reg <= (ALMOST_EMPTY_THRESHOLD >= 0);
      end else begin
        if (wr_hit[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (rd_hit[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg        <= count_next;
        full_reg         <= (count_next == NW'(DATA_DEPTH));
        empty_reg        <= (count_next == '0);
        almost_full_reg  <= (int'(count_next) >= ALMOST_FULL_THRESHOLD);
        almost_empty_reg <= (int'(count_next) <= ALMOST_EMPTY_THRESHOLD);
      end
    end

    assign wr_ptr_flat[gi*AW +: AW] = wr_ptr_reg;
    assign rd_ptr_flat[gi*AW +: AW] = rd_ptr_reg;
    assign count[gi*NW +: NW]       = count_reg;
    assign full[gi]                 = full_reg;
    assign empty[gi]                = empty_reg;
    assign almost_full[gi]          = almost_full_reg;
    assign almost_empty[gi]         = almost_empty_reg;
  end

  always_comb begin
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      if (write_channel == CW'(c)) wr_ptr_sel = wr_ptr_flat[c*AW +: AW];
      if (read_channel == CW'(c))  rd_ptr_sel = rd_ptr_flat[c*AW +: AW];
    end
  end

  assign wr_addr   = {write_channel, wr_ptr_sel};
  assign rd_addr   = {read_channel, rd_ptr_sel};
  assign wr_accept = |wr_hit;
  assign rd_accept = |rd_hit;

  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_addr] <= write_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_overflow_reg <= 1'b0;
      read_underflow_reg <= 1'b0;
    end else begin
      write_overflow_reg <= write_enable && !wr_accept;
      read_underflow_reg <= read_enable && !rd_accept;
    end
  end

  assign write_overflow = write_overflow_reg;
  assign read_underflow = read_underflow_reg;

  if (FIRST_WORD_FALL_THROUGH != 0) begin : g_fwft
    // Head word of the selected channel is presented without a clock edge.
    logic head_valid;

    always_comb begin
      head_valid = 1'b0;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        if (read_channel == CW'(c)) head_valid = ~empty[c];
      end
    end

    assign read_data         = mem[rd_addr];
    assign read_data_valid   = head_valid;
    assign read_data_channel = read_channel;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] read_data_reg;
    logic                  read_data_valid_reg;
    logic [CW-1:0]         read_data_channel_reg;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        read_data_reg         <= '0;
        read_data_valid_reg   <= 1'b0;
        read_data_channel_reg <= '0;
      end else begin
        read_data_valid_reg <= rd_accept;
        if (rd_accept) begin
          read_data_reg         <= mem[rd_addr];
          read_data_channel_reg <= read_channel;
        end
      end
    end

    assign read_data         = read_data_reg;
    assign read_data_valid   = read_data_valid_reg;
    assign read_data_channel = read_data_channel_reg;
  end

endmodule

// File: tb/tb_multi_channel_synchronous_fifo.sv
// Randomized and directed checks of three FIFO configurations against
// per-channel queue models held in the bench.
module tb_multi_channel_synchronous_fifo;
  localparam int D  = 8;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  // Instance 0: 4 ch registered, 1: 4 ch FWFT, 2: 3 ch registered.
  logic        we   [3];
  logic [1:0]  wch  [3];
  logic [15:0] wd   [3];
  logic        re   [3];
  logic [1:0]  rch  [3];
  logic [15:0] rdat [3];
  logic        rv   [3];
  logic [1:0]  rdch [3];
  logic        wovf [3];
  logic        rudf [3];
  logic [3:0]  full_w [2], empty_w [2], af_w [2], ae_w [2];
  logic [15:0] cnt_w [2];
  logic [2:0]  full_c, empty_c, af_c, ae_c;
  logic [11:0] cnt_c;

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [15:0] word_q_t[$];
  word_q_t mq [12];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    multi_channel_synchronous_fifo #(
      .DATA_WIDTH(16), .DATA_DEPTH(D), .CHANNEL_COUNT(4),
      .FIRST_WORD_FALL_THROUGH(gi), .ALMOST_FULL_THRESHOLD(6), .ALMOST_EMPTY_THRESHOLD(2)
    ) u_dut (
      .clock(clk), .reset_n(rst_n),
      .write_enable(we[gi]), .write_channel(wch[gi]), .write_data(wd[gi]),
      .read_enable(re[gi]), .read_channel(rch[gi]),
      .read_data(rdat[gi]), .read_data_valid(rv[gi]), .read_data_channel(rdch[gi]),
      .full(full_w[gi]), .empty(empty_w[gi]), .almost_full(af_w[gi]), .almost_empty(ae_w[gi]),
      .count(cnt_w[gi]), .write_overflow(wovf[gi]), .read_underflow(rudf[gi])
    );
  end

  multi_channel_synchronous_fifo #(
    .DATA_WIDTH(16), .DATA_DEPTH(D), .CHANNEL_COUNT(3),
    .FIRST_WORD_FALL_THROUGH(0), .ALMOST_FULL_THRESHOLD(6), .ALMOST_EMPTY_THRESHOLD(2)
  ) u_dut_c (
    .clock(clk), .reset_n(rst_n),
    .write_enable(we[2]), .write_channel(wch[2]), .write_data(wd[2]),
    .read_enable(re[2]), .read_channel(rch[2]),
    .read_data(rdat[2]), .read_data_valid(rv[2]), .read_data_channel(rdch[2]),
    .full(full_c), .empty(empty_c), .almost_full(af_c), .almost_empty(ae_c),
    .count(cnt_c), .write_overflow(wovf[2]), .read_underflow(rudf[2])
  );

  function automatic int cc_of(int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic int cnt_of(int i, int c);
    if (i < 2) return int'(cnt_w[i][c*NW +: NW]);
    return int'(cnt_c[c*NW +: NW]);
  endfunction

  // kind: 0 full, 1 empty, 2 almost_full, 3 almost_empty
  function automatic logic [3:0] flag_of(int i, int kind);
    logic [3:0] v;
    v = 4'h0;
    case (kind)
      0: v = (i < 2) ? full_w[i]  : {1'b0, full_c};
      1: v = (i < 2) ? empty_w[i] : {1'b0, empty_c};
      2: v = (i < 2) ? af_w[i]    : {1'b0, af_c};
      default: v = (i < 2) ? ae_w[i] : {1'b0, ae_c};
    endcase
    return v;
  endfunction

  // Drives one cycle on instance i, advances the model and returns the expectations.
  task automatic step(input int i, input logic w, input logic [1:0] wc, input logic [15:0] d,
                      input logic r, input logic [1:0] rc,
                      output logic e_ovf, output logic e_udf, output logic e_rv,
                      output logic [15:0] e_rd);
    bit w_ok, r_ok;
    w_ok = w && (int'(wc) < cc_of(i)) && (mq[i*4+int'(wc)].size() < D);
    r_ok = r && (int'(rc) < cc_of(i)) && (mq[i*4+int'(rc)].size() > 0);
    e_ovf = w && !w_ok;
    e_udf = r && !r_ok;
    e_rv  = r_ok;
    e_rd  = 16'h0;
    if (r_ok) e_rd = mq[i*4+int'(rc)].pop_front();
    if (w_ok) mq[i*4+int'(wc)].push_back(d);
    we[i] = w; wch[i] = wc; wd[i] = d; re[i] = r; rch[i] = rc;
    @(posedge clk);
    #1;
    we[i] = 1'b0;
    re[i] = 1'b0;
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) begin
      we[i] = 1'b0; re[i] = 1'b0; wch[i] = 2'd0; rch[i] = 2'd0; wd[i] = 16'h0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (mq[k]) mq[k].delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] mask;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      mask = (i < 2) ? 4'hF : 4'h7;
      for (int c = 0; c < cc_of(i); c++) begin
        n_cmp++;
        if (cnt_of(i, c) !== 0) begin
          n_bad++; $display("FAIL reset_count inst%0d ch%0d: got %0d expected 0", i, c, cnt_of(i, c));
        end
      end
      n_cmp++;
      if (flag_of(i, 1) !== mask) begin
        n_bad++; $display("FAIL reset_empty inst%0d: got %b expected %b", i, flag_of(i, 1), mask);
      end
      n_cmp++;
      if (flag_of(i, 0) !== 4'h0) begin
        n_bad++; $display("FAIL reset_full inst%0d: got %b expected 0000", i, flag_of(i, 0));
      end
      n_cmp++;
      if (flag_of(i, 3) !== mask || flag_of(i, 2) !== 4'h0) begin
        n_bad++; $display("FAIL reset_thresh inst%0d: got ae=%b af=%b", i, flag_of(i, 3), flag_of(i, 2));
      end
      n_cmp++;
      if (rv[i] !== 1'b0) begin
        n_bad++; $display("FAIL reset_valid inst%0d: got %b expected 0", i, rv[i]);
      end
    end
    n_cmp++;
    if (rdat[0] !== 16'h0 || rdch[0] !== 2'd0 || wovf[0] !== 1'b0 || rudf[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got data=%h ch=%0d ovf=%b udf=%b", rdat[0], rdch[0], wovf[0], rudf[0]);
    end
  endtask

  task automatic test_full_overflow();
    logic eo, eu, ev;
    logic [15:0] ed;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      step(0, 1'b1, 2'd2, 16'(k), 1'b0, 2'd0, eo, eu, ev, ed);
      n_cmp++;
      if (cnt_of(0, 2) !== k + 1 || full_w[0][2] !== (k == 7) || wovf[0] !== 1'b0) begin
        n_bad++; $display("FAIL fill_ch2 k=%0d: got count=%0d full=%b ovf=%b expected count=%0d", k, cnt_of(0, 2), full_w[0][2], wovf[0], k + 1);
      end
    end
    step(0, 1'b1, 2'd2, 16'hDEAD, 1'b0, 2'd0, eo, eu, ev, ed);
    n_cmp++;
    if (wovf[0] !== eo || eo !== 1'b1) begin
      n_bad++; $display("FAIL overflow_pulse: got %b expected 1", wovf[0]);
    end
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (cnt_of(0, c) !== ((c == 2) ? 8 : 0)) begin
        n_bad++; $display("FAIL overflow_counts ch%0d: got %0d expected %0d", c, cnt_of(0, c), (c == 2) ? 8 : 0);
      end
    end
    step(0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, eo, eu, ev, ed);
    n_cmp++;
    if (wovf[0] !== 1'b0) begin
      n_bad++; $display("FAIL overflow_one_cycle: got %b expected 0", wovf[0]);
    end
  endtask

  task automatic test_interleave();
    logic eo, eu, ev;
    logic [15:0] ed, last;
    logic [1:0] ch;
    apply_reset();
    last = 16'h0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 6; k++) begin
        step(0, 1'b1, 2'd0, 16'h1000 | 16'($urandom_range(0, 4095)), 1'b0, 2'd0, eo, eu, ev, ed);
        step(0, 1'b1, 2'd1, 16'h2000 | 16'($urandom_range(0, 4095)), 1'b0, 2'd0, eo, eu, ev, ed);
      end
      for (int k = 0; k < 12; k++) begin
        ch = 2'(k % 2);
        step(0, 1'b0, 2'd0, 16'h0, 1'b1, ch, eo, eu, ev, ed);
        last = ed;
        n_cmp++;
        if (rv[0] !== ev || rdat[0] !== ed || rdch[0] !== ch || rudf[0] !== 1'b0) begin
          n_bad++; $display("FAIL interleave rep%0d k%0d: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d", rep, k, rv[0], rdat[0], rdch[0], ev, ed, ch);
        end
      end
      step(0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, eo, eu, ev, ed);
      n_cmp++;
      if (rv[0] !== 1'b0 || rdat[0] !== last) begin
        n_bad++; $display("FAIL interleave_hold rep%0d: got v=%b d=%h expected v=0 d=%h", rep, rv[0], rdat[0], last);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic eo, eu, ev;
    logic [15:0] ed;
    apply_reset();
    for (int k = 0; k < 8; k++)
      step(0, 1'b1, 2'd1, 16'($urandom), 1'b0, 2'd0, eo, eu, ev, ed);
    step(0, 1'b1, 2'd1, 16'hBEEF, 1'b1, 2'd1, eo, eu, ev, ed);
    n_cmp++;
    if (wovf[0] !== 1'b1 || rudf[0] !== 1'b0 || rv[0] !== 1'b1 || rdat[0] !== ed || cnt_of(0, 1) !== D - 1) begin
      n_bad++; $display("FAIL same_ch_full: got ovf=%b udf=%b v=%b d=%h cnt=%0d expected ovf=1 udf=0 v=1 d=%h cnt=7", wovf[0], rudf[0], rv[0], rdat[0], cnt_of(0, 1), ed);
    end
    step(0, 1'b1, 2'd3, 16'h3333, 1'b1, 2'd3, eo, eu, ev, ed);
    n_cmp++;
    if (rudf[0] !== 1'b1 || wovf[0] !== 1'b0 || rv[0] !== 1'b0 || cnt_of(0, 3) !== 1) begin
      n_bad++; $display("FAIL same_ch_empty: got udf=%b ovf=%b v=%b cnt=%0d expected udf=1 ovf=0 v=0 cnt=1", rudf[0], wovf[0], rv[0], cnt_of(0, 3));
    end
    step(0, 1'b1, 2'd0, 16'h4444, 1'b1, 2'd1, eo, eu, ev, ed);
    n_cmp++;
    if (wovf[0] !== 1'b0 || rudf[0] !== 1'b0 || rv[0] !== 1'b1 || rdat[0] !== ed || cnt_of(0, 0) !== 1 || cnt_of(0, 1) !== 6) begin
      n_bad++; $display("FAIL diff_ch: got ovf=%b udf=%b v=%b d=%h c0=%0d c1=%0d expected d=%h c0=1 c1=6", wovf[0], rudf[0], rv[0], rdat[0], cnt_of(0, 0), cnt_of(0, 1), ed);
    end
  endtask

  task automatic test_fwft();
    logic eo, eu, ev;
    logic [15:0] ed, d2;
    apply_reset();
    rch[1] = 2'd3;
    #1;
    n_cmp++;
    if (rv[1] !== 1'b0) begin
      n_bad++; $display("FAIL fwft_empty_valid: got %b expected 0", rv[1]);
    end
    step(1, 1'b1, 2'd3, 16'hA5A5, 1'b0, 2'd3, eo, eu, ev, ed);
    n_cmp++;
    if (rv[1] !== 1'b1 || rdat[1] !== 16'hA5A5 || rdch[1] !== 2'd3) begin
      n_bad++; $display("FAIL fwft_head: got v=%b d=%h ch=%0d expected v=1 d=a5a5 ch=3", rv[1], rdat[1], rdch[1]);
    end
    step(1, 1'b0, 2'd0, 16'h0, 1'b1, 2'd3, eo, eu, ev, ed);
    n_cmp++;
    if (rv[1] !== 1'b0 || cnt_of(1, 3) !== 0) begin
      n_bad++; $display("FAIL fwft_pop: got v=%b cnt=%0d expected v=0 cnt=0", rv[1], cnt_of(1, 3));
    end
    for (int k = 0; k < 5; k++)
      step(1, 1'b1, 2'd0, 16'($urandom), 1'b0, 2'd0, eo, eu, ev, ed);
    d2 = 16'($urandom);
    step(1, 1'b1, 2'd2, d2, 1'b0, 2'd0, eo, eu, ev, ed);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (rv[1] !== 1'b1 || rdat[1] !== mq[4][0]) begin
        n_bad++; $display("FAIL fwft_seq k%0d: got v=%b d=%h expected v=1 d=%h", k, rv[1], rdat[1], mq[4][0]);
      end
      step(1, 1'b0, 2'd0, 16'h0, 1'b1, 2'd0, eo, eu, ev, ed);
    end
    n_cmp++;
    if (rv[1] !== 1'b0) begin
      n_bad++; $display("FAIL fwft_drained: got %b expected 0", rv[1]);
    end
    rch[1] = 2'd2;
    #1;
    n_cmp++;
    if (rv[1] !== 1'b1 || rdat[1] !== d2 || rdch[1] !== 2'd2) begin
      n_bad++; $display("FAIL fwft_switch: got v=%b d=%h ch=%0d expected v=1 d=%h ch=2", rv[1], rdat[1], rdch[1], d2);
    end
  endtask

  task automatic test_thresholds();
    logic eo, eu, ev;
    logic [15:0] ed;
    int n;
    apply_reset();
    step(2, 1'b1, 2'd3, 16'h7777, 1'b0, 2'd0, eo, eu, ev, ed);
    n_cmp++;
    if (wovf[2] !== eo || cnt_c !== 12'h0) begin
      n_bad++; $display("FAIL invalid_write: got ovf=%b count=%h expected ovf=%b count=000", wovf[2], cnt_c, eo);
    end
    step(2, 1'b0, 2'd0, 16'h0, 1'b1, 2'd3, eo, eu, ev, ed);
    n_cmp++;
    if (rudf[2] !== eu || rv[2] !== 1'b0) begin
      n_bad++; $display("FAIL invalid_read: got udf=%b v=%b expected udf=%b v=0", rudf[2], rv[2], eu);
    end
    for (int k = 0; k < 16; k++) begin
      if (k < 8) step(2, 1'b1, 2'd1, 16'($urandom), 1'b0, 2'd0, eo, eu, ev, ed);
      else       step(2, 1'b0, 2'd0, 16'h0, 1'b1, 2'd1, eo, eu, ev, ed);
      n = mq[9].size();
      n_cmp++;
      if (af_c[1] !== (n >= 6) || ae_c[1] !== (n <= 2) || cnt_of(2, 1) !== n) begin
        n_bad++; $display("FAIL thresholds k%0d: got af=%b ae=%b cnt=%0d expected cnt=%0d", k, af_c[1], ae_c[1], cnt_of(2, 1), n);
      end
    end
    for (int k = 0; k < 3; k++) step(2, 1'b1, 2'd0, 16'($urandom), 1'b0, 2'd0, eo, eu, ev, ed);
    for (int k = 0; k < 2; k++) step(2, 1'b1, 2'd2, 16'($urandom), 1'b0, 2'd0, eo, eu, ev, ed);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (empty_c !== 3'b111 || cnt_c !== 12'h0 || rv[2] !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got empty=%b count=%h v=%b expected 111 000 0", empty_c, cnt_c, rv[2]);
    end
    foreach (mq[k]) mq[k].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2, 1'b0, 2'd0, 16'h0, 1'b1, 2'd0, eo, eu, ev, ed);
    n_cmp++;
    if (rudf[2] !== 1'b1 || rv[2] !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_read: got udf=%b v=%b expected udf=1 v=0", rudf[2], rv[2]);
    end
  endtask

  task automatic test_random();
    logic eo, eu, ev, w, r;
    logic [15:0] ed;
    logic [1:0] wc, rc;
    logic [3:0] fe, ff;
    int i;
    apply_reset();
    for (int t = 0; t < 600; t++) begin
      i  = (t % 2 == 0) ? 0 : 2;
      w  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 45);
      wc = 2'($urandom_range(0, 3));
      rc = 2'($urandom_range(0, 3));
      step(i, w, wc, 16'($urandom), r, rc, eo, eu, ev, ed);
      n_cmp++;
      if (wovf[i] !== eo || rudf[i] !== eu || rv[i] !== ev || (ev && (rdat[i] !== ed || rdch[i] !== rc))) begin
        n_bad++; $display("FAIL random t%0d inst%0d: got ovf=%b udf=%b v=%b d=%h ch=%0d expected ovf=%b udf=%b v=%b d=%h ch=%0d", t, i, wovf[i], rudf[i], rv[i], rdat[i], rdch[i], eo, eu, ev, ed, rc);
      end
      fe = flag_of(i, 1);
      ff = flag_of(i, 0);
      for (int c = 0; c < cc_of(i); c++) begin
        n_cmp++;
        if (cnt_of(i, c) !== mq[i*4+c].size() || fe[c] !== (mq[i*4+c].size() == 0) || ff[c] !== (mq[i*4+c].size() == D)) begin
          n_bad++; $display("FAIL random_state t%0d inst%0d ch%0d: got cnt=%0d e=%b f=%b expected cnt=%0d", t, i, c, cnt_of(i, c), fe[c], ff[c], mq[i*4+c].size());
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      we[i] = 1'b0; re[i] = 1'b0; wch[i] = 2'd0; rch[i] = 2'd0; wd[i] = 16'h0;
    end
    test_reset();
    test_full_overflow();
    test_interleave();
    test_simultaneous();
    test_fwft();
    test_thresholds();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
